// File: rtl/motor_cmd_parser.sv
// ASCII motor command frame parser: {"T":d,"L":v,"R":v}\n -> speeds.
// Fields build in shadow registers and commit only after the closing LF.
module motor_cmd_parser #(
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_rx_valid,
  output logic        uart_rx_ready,
  output logic        cmd_valid,
  output logic [3:0]  cmd_t,
  output logic [10:0] cmd_left,
  output logic [10:0] cmd_right,
  output logic [4:0]  motor_state,
  output logic        parse_error
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    WAIT_OPEN, KEY_Q1, KEY_CHAR, KEY_Q2, COLON,
    VAL_FIRST, VAL_INT, VAL_DOT, FRAC1, FRAC2, WAIT_LF
  } state_t;

  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]  idx_q, idx_d;
  logic        neg_q, neg_d;
  logic [3:0]  int_q, int_d;
  logic [3:0]  f1_q, f1_d;
  logic [3:0]  f2_q, f2_d;
  logic        f2s_q, f2s_d;
  logic [3:0]  t_sh_q, t_sh_d;
  logic [10:0] l_sh_q, l_sh_d;
  logic [10:0] r_sh_q, r_sh_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;
  logic [3:0]  t_q, t_d;
  logic [10:0] left_q, left_d;
  logic [10:0] right_q, right_d;
  logic [4:0]  ms_q, ms_d;

  logic       acc, is_dig, bad, clr;
  logic [3:0] dv;
  logic [7:0] key, sep;
  logic [9:0] mag;
  logic [10:0] sval;
  logic [4:0] cls;
  logic l_zero, r_zero, l_pos, r_pos, l_neg;

  assign uart_rx_ready = reset;
  assign acc    = uart_rx_valid & uart_rx_ready;
  assign is_dig = (uart_rx_data >= 8'h30) && (uart_rx_data <= 8'h39);
  assign dv     = uart_rx_data[3:0];
  assign sep    = (idx_q == 2'd2) ? 8'h7D : 8'h2C;
  assign mag    = {6'd0, int_q} * 10'd100
                + {6'd0, f1_q} * 10'd10
                + {6'd0, f2_q};
  assign sval   = neg_q ? (11'd0 - {1'b0, mag}) : {1'b0, mag};

  always_comb begin
    key = 8'h54;
    unique case (idx_q)
      2'd1:    key = 8'h4C;
      2'd2:    key = 8'h52;
      default: key = 8'h54;
    endcase
  end

  assign l_zero = (l_sh_q == 11'd0);
  assign r_zero = (r_sh_q == 11'd0);
  assign l_neg  = l_sh_q[10];
  assign l_pos  = !l_sh_q[10] && !l_zero;
  assign r_pos  = !r_sh_q[10] && !r_zero;

  always_comb begin
    cls = 5'b00001;
    unique case (1'b1)
      l_zero && r_zero:           cls = 5'b00001;
      l_pos && (l_sh_q == r_sh_q): cls = 5'b00010;
      l_zero && r_pos:            cls = 5'b00100;
      l_pos && r_zero:            cls = 5'b01000;
      l_neg && r_pos:             cls = 5'b10000;
      default:                    cls = 5'b00001;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    neg_d   = neg_q;
    int_d   = int_q;
    f1_d    = f1_q;
    f2_d    = f2_q;
    f2s_d   = f2s_q;
    t_sh_d  = t_sh_q;
    l_sh_d  = l_sh_q;
    r_sh_d  = r_sh_q;
    t_d     = t_q;
    left_d  = left_q;
    right_d = right_q;
    ms_d    = ms_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
    bad     = 1'b0;
    clr     = 1'b0;

    if (acc) begin
      cnt_d = '0;
      unique case (state_q)
        WAIT_OPEN: if (uart_rx_data == 8'h7B) begin
          state_d = KEY_Q1;
          clr     = 1'b1;
        end
        KEY_Q1: if (uart_rx_data == 8'h22) state_d = KEY_CHAR;
                else bad = 1'b1;
        KEY_CHAR: if (uart_rx_data == key) state_d = KEY_Q2;
                  else bad = 1'b1;
        KEY_Q2: if (uart_rx_data == 8'h22) state_d = COLON;
                else bad = 1'b1;
        COLON: if (uart_rx_data == 8'h3A) begin
          state_d = VAL_FIRST;
          neg_d   = 1'b0;
          int_d   = '0;
          f1_d    = '0;
          f2_d    = '0;
          f2s_d   = 1'b0;
        end else bad = 1'b1;
        VAL_FIRST: if (is_dig) begin
          int_d   = dv;
          state_d = VAL_DOT;
        end else if (uart_rx_data == 8'h2D && idx_q != 2'd0) begin
          neg_d   = 1'b1;
          state_d = VAL_INT;
        end else bad = 1'b1;
        VAL_INT: if (is_dig) begin
          int_d   = dv;
          state_d = VAL_DOT;
        end else bad = 1'b1;
        VAL_DOT: if (uart_rx_data == 8'h2E && idx_q != 2'd0)
          state_d = FRAC1;
        else if (uart_rx_data != sep) bad = 1'b1;
        FRAC1: if (is_dig) begin
          f1_d    = dv;
          state_d = FRAC2;
        end else bad = 1'b1;
        FRAC2: if (is_dig && !f2s_q) begin
          f2_d  = dv;
          f2s_d = 1'b1;
        end else if (uart_rx_data != sep) bad = 1'b1;
        WAIT_LF: if (uart_rx_data == 8'h0A) begin
          t_d     = t_sh_q;
          left_d  = l_sh_q;
          right_d = r_sh_q;
          ms_d    = cls;
          valid_d = 1'b1;
          clr     = 1'b1;
          state_d = WAIT_OPEN;
        end else bad = 1'b1;
        default: state_d = WAIT_OPEN;
      endcase

      // Separator closes the current field; commit it to its shadow slot.
      if (!bad && (state_q == VAL_DOT || state_q == FRAC2)
          && uart_rx_data == sep) begin
        unique case (idx_q)
          2'd0:    t_sh_d = int_q;
          2'd1:    l_sh_d = sval;
          default: r_sh_d = sval;
        endcase
        if (idx_q == 2'd2) state_d = WAIT_LF;
        else begin
          idx_d   = idx_q + 2'd1;
          state_d = KEY_Q1;
        end
      end

      if (bad) begin
        err_d   = 1'b1;
        clr     = 1'b1;
        state_d = (uart_rx_data == 8'h7B) ? KEY_Q1 : WAIT_OPEN;
      end
    end else if (state_q != WAIT_OPEN) begin
      if (cnt_q == CNT_LAST) begin
        err_d   = 1'b1;
        clr     = 1'b1;
        cnt_d   = '0;
        state_d = WAIT_OPEN;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    if (clr) begin
      idx_d  = '0;
      neg_d  = 1'b0;
      int_d  = '0;
      f1_d   = '0;
      f2_d   = '0;
      f2s_d  = 1'b0;
      t_sh_d = '0;
      l_sh_d = '0;
      r_sh_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= WAIT_OPEN;
      cnt_q   <= '0;
      idx_q   <= '0;
      neg_q   <= 1'b0;
      int_q   <= '0;
      f1_q    <= '0;
      f2_q    <= '0;
      f2s_q   <= 1'b0;
      t_sh_q  <= '0;
      l_sh_q  <= '0;
      r_sh_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      t_q     <= '0;
      left_q  <= '0;
      right_q <= '0;
      ms_q    <= 5'b00001;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      neg_q   <= neg_d;
      int_q   <= int_d;
      f1_q    <= f1_d;
      f2_q    <= f2_d;
      f2s_q   <= f2s_d;
      t_sh_q  <= t_sh_d;
      l_sh_q  <= l_sh_d;
      r_sh_q  <= r_sh_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      t_q     <= t_d;
      left_q  <= left_d;
      right_q <= right_d;
      ms_q    <= ms_d;
    end
  end

  assign cmd_valid   = valid_q;
  assign parse_error = err_q;
  assign cmd_t       = t_q;
  assign cmd_left    = left_q;
  assign cmd_right   = right_q;
  assign motor_state = ms_q;

endmodule

// File: tb/tb_motor_cmd_parser.sv
// Directed bench for motor_cmd_parser with hand-computed expectations.
module tb_motor_cmd_parser;

  localparam int TO = 20;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  uart_rx_data;
  logic        uart_rx_valid;
  logic        uart_rx_ready;
  logic        cmd_valid;
  logic [3:0]  cmd_t;
  logic [10:0] cmd_left;
  logic [10:0] cmd_right;
  logic [4:0]  motor_state;
  logic        parse_error;

  int n_chk  = 0;
  int n_fail = 0;
  int vc = 0, ec = 0, both = 0;
  int e0, v0;

  motor_cmd_parser #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk),
    .reset(reset),
    .uart_rx_data(uart_rx_data),
    .uart_rx_valid(uart_rx_valid),
    .uart_rx_ready(uart_rx_ready),
    .cmd_valid(cmd_valid),
    .cmd_t(cmd_t),
    .cmd_left(cmd_left),
    .cmd_right(cmd_right),
    .motor_state(motor_state),
    .parse_error(parse_error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (cmd_valid) vc++;
    if (parse_error) ec++;
    if (cmd_valid && parse_error) both++;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    uart_rx_data  = b;
    uart_rx_valid = 1'b1;
    @(posedge clk);
    #1;
    uart_rx_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic [3:0] t,
                         input logic [10:0] l, input logic [10:0] r,
                         input logic [4:0] ms);
    chk({tag, "_t"}, 32'(cmd_t), 32'(t));
    chk({tag, "_l"}, 32'(cmd_left), 32'(l));
    chk({tag, "_r"}, 32'(cmd_right), 32'(r));
    chk({tag, "_ms"}, 32'(motor_state), 32'(ms));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    uart_rx_valid = 1'b0;
    uart_rx_data = 8'h00;
    idle(3);
    chk("rst_ready", 32'(uart_rx_ready), 0);
    chk("rst_valid", 32'(cmd_valid), 0);
    chk("rst_err", 32'(parse_error), 0);
    chk_out("rst", 4'd0, 11'd0, 11'd0, 5'b00001);
    reset = 1'b1;
    idle(1);
    chk("ready_up", 32'(uart_rx_ready), 1);

    // forward frame, latency one cycle after LF
    send_str("{\"T\":1,\"L\":0.10,\"R\":0.10}");
    chk("no_early_valid", 32'(cmd_valid), 0);
    send_byte(8'h0A);
    chk("valid_lat", 32'(cmd_valid), 1);
    chk_out("fwd", 4'd1, 11'd10, 11'd10, 5'b00010);
    idle(1);
    chk("valid_one", 32'(cmd_valid), 0);

    // spin
    send_str("{\"T\":1,\"L\":-0.1,\"R\":0.10}\n");
    chk("spin_valid", 32'(cmd_valid), 1);
    chk_out("spin", 4'd1, 11'h7F6, 11'd10, 5'b10000);
    idle(2);

    // third fraction digit
    e0 = ec; v0 = vc;
    send_str("{\"T\":1,\"L\":0.12");
    chk("no_err_before3", 32'(parse_error), 0);
    send_byte("3");
    chk("err_3rd_frac", 32'(parse_error), 1);
    idle(2);
    chk("err_3rd_cnt", 32'(ec - e0), 1);
    chk_out("hold", 4'd1, 11'h7F6, 11'd10, 5'b10000);
    send_str("{\"T\":5,\"L\":1,\"R\":-2.5}\n");
    chk_out("mixed", 4'd5, 11'd100, 11'h706, 5'b00001);
    idle(2);
    chk("mixed_vcnt", 32'(vc - v0), 1);

    // broken key, then restart
    e0 = ec; v0 = vc;
    send_str("{\"T\":1,\"L {\"T\":1,\"L\":0.00,\"R\":0.10}\n");
    chk("right_valid", 32'(cmd_valid), 1);
    chk_out("right", 4'd1, 11'd0, 11'd10, 5'b00100);
    idle(2);
    chk("restart_ecnt", 32'(ec - e0), 1);
    chk("restart_vcnt", 32'(vc - v0), 1);

    // rejected grammar variants, one error each
    e0 = ec;
    send_str("{\"T\":-"); idle(2);
    chk("t_minus", 32'(ec - e0), 1);
    send_str("{\"T\":1."); idle(2);
    chk("t_dot", 32'(ec - e0), 2);
    send_str("{\"X"); idle(2);
    chk("bad_key", 32'(ec - e0), 3);
    send_str("{\"T\":1,\"L\":12"); idle(2);
    chk("two_int", 32'(ec - e0), 4);
    send_str("{\"T\":1,\"L\":0.x"); idle(2);
    chk("dot_nondig", 32'(ec - e0), 5);
    send_str("abc\n}"); idle(2);
    chk("idle_ignore", 32'(ec - e0), 5);
    send_str("{\"T\":9,\"L\":2,\"R\":0}\n");
    chk_out("left", 4'd9, 11'd200, 11'd0, 5'b01000);
    send_str("{\"T\":0,\"L\":-0,\"R\":0}\n");
    chk_out("negzero", 4'd0, 11'd0, 11'd0, 5'b00001);
    idle(2);

    // timeout
    e0 = ec;
    send_str("{\"T\"");
    repeat (TO - 1) @(posedge clk);
    #1;
    chk("to_not_yet", 32'(parse_error), 0);
    idle(1);
    chk("to_pulse", 32'(parse_error), 1);
    idle(2 * TO);
    chk("to_once", 32'(ec - e0), 1);

    // byte on expiry cycle wins
    e0 = ec; v0 = vc;
    send_str("{\"T\"");
    repeat (TO - 1) @(posedge clk);
    #1;
    send_str(":3,\"L\":0,\"R\":0}\n");
    chk("exp_byte_valid", 32'(cmd_valid), 1);
    chk("exp_byte_t", 32'(cmd_t), 3);
    idle(2);
    chk("exp_byte_noerr", 32'(ec - e0), 0);

    // reset mid-frame
    send_str("{\"T\":1,\"L\":0.");
    e0 = ec; v0 = vc;
    reset = 1'b0;
    idle(3);
    chk("mid_rst_ready", 32'(uart_rx_ready), 0);
    reset = 1'b1;
    idle(1);
    chk_out("mid_rst", 4'd0, 11'd0, 11'd0, 5'b00001);
    send_str(",\"R\":0}\n");
    idle(2);
    chk("mid_rst_noerr", 32'(ec - e0), 0);
    chk("mid_rst_noval", 32'(vc - v0), 0);
    chk_out("mid_hold", 4'd0, 11'd0, 11'd0, 5'b00001);
    send_str("{\"T\":2,\"L\":0.05,\"R\":0.05}\n");
    chk_out("post_rst", 4'd2, 11'd5, 11'd5, 5'b00010);
    idle(2);
    chk("never_both", 32'(both), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/motor_cmd_parser.md
MOTOR_CMD_PARSER -- requirements
Module: motor_cmd_parser

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 50_000_000, meaning the maximum idle clock cycles allowed between bytes inside a frame.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-004 SHALL have port uart_rx_data, input, 8 bits: received ASCII byte.
REQ-005 SHALL have port uart_rx_valid, input, 1 bit: uart_rx_data is valid this cycle.
REQ-006 SHALL have port uart_rx_ready, output, 1 bit: parser can accept a byte.
REQ-007 SHALL have port cmd_valid, output, 1 bit: one-cycle pulse when a complete frame has been accepted.
REQ-008 SHALL have port cmd_t, output, 4 bits: T digit from the last good frame.
REQ-009 SHALL have port cmd_left, output, 11 bits: signed L speed in hundredths, two's complement.
REQ-010 SHALL have port cmd_right, output, 11 bits: signed R speed in hundredths, two's complement.
REQ-011 SHALL have port motor_state, output, 5 bits: one-hot class of the last good frame.
REQ-012 SHALL have port parse_error, output, 1 bit: one-cycle pulse when a frame is aborted.

Function
REQ-013 SHALL accept a byte only in a cycle where uart_rx_valid=1 and uart_rx_ready=1; uart_rx_ready SHALL be 1 whenever reset is deasserted.
REQ-014 SHALL accept only this exact frame grammar, with no whitespace: '{' "T" ':' D ',' "L" ':' V ',' "R" ':' V '}' LF (0x0A).
- D is a single ASCII digit.
- V is an optional '-', then exactly one integer digit, then optionally '.' followed by 1 or 2 fraction digits.
REQ-015 SHALL use these FSM states: WAIT_OPEN, KEY_Q1, KEY_CHAR, KEY_Q2, COLON, VAL_FIRST, VAL_INT, VAL_DOT, FRAC1, FRAC2, WAIT_LF.
- A 2-bit field index (T=0, L=1, R=2) selects the expected key character in KEY_CHAR and the expected separator.
- Separator after fields T and L is ','; separator after field R is '}'.
REQ-016 SHALL compute magnitude = int*100 + f1*10 + f2, with missing fraction digits taken as 0.
- Examples: "0.1" -> 10, "0.05" -> 5, "1" -> 100, "-0.1" -> -10, "-0" -> 0.
REQ-017 SHALL build each field in shadow registers; cmd_t, cmd_left, cmd_right and motor_state SHALL change only when a full frame, including LF, has been accepted.
REQ-018 SHALL update the outputs and pulse cmd_valid in the cycle after the LF is accepted (latency 1); outputs SHALL hold their values until the next good frame.
REQ-019 SHALL reject field T if it carries a '-' or '.'.
REQ-020 SHALL, on any unexpected byte: pulse parse_error for one cycle, discard the shadow registers, and return to WAIT_OPEN.
- If the offending byte is '{', it SHALL instead be treated as the start of a new frame, entering KEY_Q1.
REQ-021 SHALL treat these as unexpected bytes: a second integer digit, a third fraction digit, '.' followed by a non-digit, and a wrong key letter.
REQ-022 SHALL silently ignore every byte other than '{' while in WAIT_OPEN.
REQ-023 SHALL run an inter-byte counter in every state except WAIT_OPEN; the counter SHALL clear on each accepted byte.
- On reaching TIMEOUT_CYCLES the parser SHALL pulse parse_error and go to WAIT_OPEN.
- If a byte is accepted in the same cycle the counter expires, the byte wins and no timeout occurs.
REQ-024 SHALL derive motor_state from the new L and R values as follows:
- L=R=0 -> 00001 (stop).
- L=R>0 -> 00010 (forward).
- L=0, R>0 -> 00100 (right).
- L>0, R=0 -> 01000 (left).
- L<0, R>0 -> 10000 (spin).
- Any other combination -> 00001.
REQ-025 SHALL never assert cmd_valid and parse_error in the same cycle.

Reset
REQ-026 SHALL, while reset=0 at a rising clk edge, enter WAIT_OPEN and clear the shadow registers and the timeout counter.
REQ-027 SHALL drive these reset values: cmd_valid=0, parse_error=0, cmd_t=0, cmd_left=0, cmd_right=0, motor_state=00001, uart_rx_ready=0.
REQ-028 SHALL discard any partially received frame on reset, with no cmd_valid and no parse_error pulse.

Verification
REQ-029 Bench SHALL send {"T":1,"L":0.10,"R":0.10}LF -> one cmd_valid pulse one cycle after LF; cmd_t=1, cmd_left=10, cmd_right=10, motor_state=00010.
REQ-030 Bench SHALL send {"T":1,"L":-0.1,"R":0.10}LF -> cmd_left=-10 (11'h7F6), cmd_right=10, motor_state=10000.
REQ-031 Bench SHALL send {"T":1,"L":0.123 -> parse_error pulse on the '3'; outputs unchanged; a following good frame is decoded correctly.
REQ-032 Bench SHALL send {"T":1,"L {"T":1,"L":0.00,"R":0.10}LF -> one parse_error pulse, then cmd_valid with motor_state=00100.
REQ-033 Bench SHALL send {"T" then idle for TIMEOUT_CYCLES -> parse_error pulse exactly once; a byte arriving on the expiry cycle -> no error.
REQ-034 Bench SHALL assert reset=0 mid-frame, then send a full good frame -> no pulse during reset; the good frame decodes normally; outputs equal the reset values until then.
